aes_gcm_out_framer: RTL and testbench
=====================================

Name: aes_gcm_out_framer

Overview:
- Output stage directly downstream of the GCM top level. Consumes the payload-out stream and the final tag/auth status, and emits one framed output stream per message.
- Encrypt: emits ciphertext beats, then appends the tag as a final beat.
- Decrypt: holds the last plaintext beat until authentication resolves, then releases it tagged with pass/fail.
- Adds a tag-wait timeout so a stalled core cannot hang the egress.

Parameters:
- TAG_BYTES, 16, tag bytes emitted on the tag beat (legal 12..16).
- TAG_TIMEOUT, 1024, cycles to wait in WAIT_TAG before flagging timeout (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  message start pulse (same pulse fed to the core)
- enc_mode  in  1  sampled at start: 1 = encrypt, 0 = decrypt
- pld_zero  in  1  sampled at start: payload length is 0
- in_valid / in_ready  in/out  1/1  payload from core dout
- in_last  in  1  last payload beat
- in_data  in  128  payload beat; byte i = in_data[127-8i -: 8]
- in_keep  in  16  byte enables; keep[15-i] qualifies byte i
- tag_in  in  128  computed tag
- tag_valid  in  1  tag_in/auth_fail valid (pulse or level)
- auth_fail  in  1  decrypt authentication failure
- out_valid / out_ready  out/in  1/1  framed output handshake
- out_last  out  1  final beat of frame
- out_data  out  128  output beat
- out_keep  out  16  output byte enables
- out_tag  out  1  current beat is the tag beat
- out_auth_fail  out  1  valid on decrypt last beat: 1 = tag mismatch
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the last beat handshakes
- timeout_err  out  1  sticky until next accepted start; set on tag timeout

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: all outputs 0; state IDLE; tag_seen, counters and output register cleared. Reset mid-frame discards the frame.
- Output register: single registered output slot.
  - A beat accepted at cycle N is presented at N+1.
  - The slot empties on out_valid && out_ready.
  - in_ready = (state==PAYLOAD) && (!out_valid || out_ready) && !hold.
  - Output fields are stable while out_valid && !out_ready.
- tag_seen: a sticky capture of tag_in/auth_fail on any tag_valid while busy, so an early tag is never lost. Cleared on start.
- IDLE:
  - start latches enc_mode and pld_zero, clears timeout_err, and goes to PAYLOAD. If pld_zero, it goes to WAIT_TAG instead.
  - in_ready = 0 in IDLE. start while busy is ignored.
- PAYLOAD:
  - Beats pass through with out_tag=0, out_last=0, data and keep unchanged.
  - Encrypt, accepted in_last: next state WAIT_TAG.
  - Decrypt, accepted in_last: the beat is loaded with out_valid held low (hold=1), then WAIT_TAG.
- WAIT_TAG:
  - The counter increments each cycle until tag_seen.
  - On tag_seen, encrypt: load the tag beat. out_data = tag_in; out_keep = top TAG_BYTES bits set (e.g. TAG_BYTES=12 → 16'hFFF0); out_tag=1; out_last=1.
  - On tag_seen, decrypt: release the held beat with out_last=1 and out_auth_fail = captured auth_fail.
  - Decrypt with pld_zero: emit one beat with out_keep=0, out_data=0, out_last=1 and out_auth_fail.
  - Counter reaching TAG_TIMEOUT without tag_seen:
    - set timeout_err;
    - emit the closing beat (encrypt: keep=0, out_tag=1, last=1; decrypt: held beat with out_auth_fail=1);
    - go to FLUSH.
  - Tag load happens the cycle after tag_seen is set (or the same cycle if already set on entry). Then go to FLUSH.
- FLUSH: wait for the last-beat handshake, then pulse done and return to IDLE.
- Simultaneous events:
  - tag_valid in the same cycle as the in_last accept is captured; the frame completes normally.
  - out_ready is low during tag load: the tag is held until accepted.

Test Plan:
- Encrypt, 3 full beats (keep=16'hFFFF), out_ready=1, tag_valid 2 cycles after last beat with tag_in=128'h0123…CDEF → 4 output beats. Beats 0–2 have out_tag=0, last=0. Beat 3 carries tag_in, keep=FFFF, out_tag=1, last=1. done pulses once.
- Decrypt, 2 beats, last beat keep=16'hFF00, auth_fail=1 arriving 5 cycles later → beat 1 appears only after tag_valid, with keep=FF00, last=1, out_auth_fail=1.
- Encrypt, TAG_BYTES=12, tag_valid asserted before in_last → tag captured early. Tag beat keep=16'hFFF0, no extra stall beyond one cycle.
- Backpressure: out_ready toggling 1010… over a 4-beat encrypt → no beat lost or duplicated, out_data stable while stalled, in_ready low whenever the slot is full and out_ready=0.
- pld_zero=1 decrypt, auth_fail=0 → single beat with keep=0, last=1, out_auth_fail=0. With TAG_TIMEOUT=8 and no tag_valid → timeout_err=1 after 8 cycles, closing beat has out_auth_fail=1.
- Assert rst for one cycle mid-PAYLOAD → all outputs 0 immediately. Next start runs a clean 1-beat frame.

Source files
------------

// File: rtl/aes_gcm_out_framer.sv
// aes_gcm_out_framer: frames GCM payload-out into one egress stream per message,
// appending the tag (encrypt) or releasing the last beat with auth status (decrypt).
module aes_gcm_out_framer #(
    parameter int TAG_BYTES   = 16,
    parameter int TAG_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enc_mode,
    input  logic         pld_zero,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [127:0] in_data,
    input  logic [15:0]  in_keep,
    input  logic [127:0] tag_in,
    input  logic         tag_valid,
    input  logic         auth_fail,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [127:0] out_data,
    output logic [15:0]  out_keep,
    output logic         out_tag,
    output logic         out_auth_fail,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);
    localparam int CW = $clog2(TAG_TIMEOUT + 1);
    localparam logic [15:0] TAG_KEEP = ~(16'hFFFF >> TAG_BYTES);
    typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_TAG, FLUSH} state_t;
    state_t         state_q, state_d;
    logic           enc_q, enc_d, pz_q, pz_d;
    logic           tag_seen_q, tag_seen_d, af_q, af_d;
    logic [127:0]   tag_q, tag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_err_q, timeout_err_d, hold_q, hold_d;
    logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic           out_tag_q, out_tag_d, out_auth_fail_q, out_auth_fail_d;
    logic [127:0]   out_data_q, out_data_d;
    logic [15:0]    out_keep_q, out_keep_d;
    logic           slot_free, to_fire;
    always_comb begin
        state_d         = state_q;
        enc_d           = enc_q;
        pz_d            = pz_q;
        tag_seen_d      = tag_seen_q;
        tag_d           = tag_q;
        af_d            = af_q;
        cnt_d           = cnt_q;
        timeout_err_d   = timeout_err_q;
        hold_d          = hold_q;
        out_valid_d     = out_valid_q && !out_ready;
        out_last_d      = out_last_q;
        out_tag_d       = out_tag_q;
        out_auth_fail_d = out_auth_fail_q;
        out_data_d      = out_data_q;
        out_keep_d      = out_keep_q;
        busy            = state_q != IDLE;
        slot_free       = !out_valid_q || out_ready;
        in_ready        = (state_q == PAYLOAD) && slot_free && !hold_q;
        to_fire         = !tag_seen_q && (cnt_q == CW'(TAG_TIMEOUT - 1));
        done            = (state_q == FLUSH) && out_valid_q && out_ready && out_last_q;
        // First tag report while busy wins; an early tag must survive until WAIT_TAG
        if (busy && tag_valid && !tag_seen_q) begin
            tag_seen_d = 1'b1;
            tag_d      = tag_in;
            af_d       = auth_fail;
        end
        case (state_q)
            IDLE: if (start) begin
                state_d       = pld_zero ? WAIT_TAG : PAYLOAD;
                enc_d         = enc_mode;
                pz_d          = pld_zero;
                timeout_err_d = 1'b0;
                tag_seen_d    = 1'b0;
                cnt_d         = '0;
                hold_d        = 1'b0;
            end
            PAYLOAD: if (in_valid && in_ready) begin
                out_data_d      = in_data;
                out_keep_d      = in_keep;
                out_tag_d       = 1'b0;
                out_last_d      = 1'b0;
                out_auth_fail_d = 1'b0;
                hold_d          = in_last && !enc_q;
                out_valid_d     = !(in_last && !enc_q);
                state_d         = in_last ? WAIT_TAG : PAYLOAD;
            end
            WAIT_TAG: begin
                if (!tag_seen_q && !to_fire)
                    cnt_d = cnt_q + CW'(1);
                if ((tag_seen_q || to_fire) && slot_free) begin
                    out_valid_d   = 1'b1;
                    out_last_d    = 1'b1;
                    hold_d        = 1'b0;
                    timeout_err_d = timeout_err_q | to_fire;
                    state_d       = FLUSH;
                    if (enc_q) begin
                        out_data_d      = tag_seen_q ? tag_q : '0;
                        out_keep_d      = tag_seen_q ? TAG_KEEP : '0;
                        out_tag_d       = 1'b1;
                        out_auth_fail_d = 1'b0;
                    end else begin
                        // Held last beat keeps its data/keep; empty payload emits a null beat
                        out_data_d      = pz_q ? '0 : out_data_q;
                        out_keep_d      = pz_q ? '0 : out_keep_q;
                        out_tag_d       = 1'b0;
                        out_auth_fail_d = tag_seen_q ? af_q : 1'b1;
                    end
                end
            end
            FLUSH: state_d = done ? IDLE : FLUSH;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            enc_q           <= 1'b0;
            pz_q            <= 1'b0;
            tag_seen_q      <= 1'b0;
            tag_q           <= '0;
            af_q            <= 1'b0;
            cnt_q           <= '0;
            timeout_err_q   <= 1'b0;
            hold_q          <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_tag_q       <= 1'b0;
            out_auth_fail_q <= 1'b0;
            out_data_q      <= '0;
            out_keep_q      <= '0;
        end else begin
            state_q         <= state_d;
            enc_q           <= enc_d;
            pz_q            <= pz_d;
            tag_seen_q      <= tag_seen_d;
            tag_q           <= tag_d;
            af_q            <= af_d;
            cnt_q           <= cnt_d;
            timeout_err_q   <= timeout_err_d;
            hold_q          <= hold_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            out_tag_q       <= out_tag_d;
            out_auth_fail_q <= out_auth_fail_d;
            out_data_q      <= out_data_d;
            out_keep_q      <= out_keep_d;
        end
    end
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_tag       = out_tag_q;
    assign out_auth_fail = out_auth_fail_q;
    assign out_data      = out_data_q;
    assign out_keep      = out_keep_q;
    assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_aes_gcm_out_framer.sv
// tb_aes_gcm_out_framer: directed bench; u0 uses default parameters, u1 uses TAG_BYTES=12, TAG_TIMEOUT=8.
module tb_aes_gcm_out_framer;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 0, enc_mode = 0, pld_zero = 0, in_valid = 0, in_last = 0;
    logic tag_valid = 0, auth_fail = 0, out_ready = 1, tog = 0;
    logic [127:0] in_data = '0, tag_in = '0;
    logic [15:0]  in_keep = '0;
    logic in_ready0, out_valid0, out_last0, out_tag0, out_af0, busy0, done0, terr0;
    logic in_ready1, out_valid1, out_last1, out_tag1, out_af1, busy1, done1, terr1;
    logic [127:0] out_data0, out_data1;
    logic [15:0]  out_keep0, out_keep1;
    typedef struct {logic [127:0] d; logic [15:0] k; logic l; logic t; logic a; int c;} beat_t;
    beat_t q0[$], q1[$];
    int checks = 0, errors = 0, d0 = 0, d1 = 0, cyc = 0;
    logic stall0 = 0;
    logic [127:0] sdata0 = '0;
    localparam logic [127:0] TAG = 128'h0123456789ABCDEF0123456789ABCDEF;

    aes_gcm_out_framer u0 (
        .clk(clk), .rst(rst), .start(start), .enc_mode(enc_mode), .pld_zero(pld_zero),
        .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last), .in_data(in_data),
        .in_keep(in_keep), .tag_in(tag_in), .tag_valid(tag_valid), .auth_fail(auth_fail),
        .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0), .out_data(out_data0),
        .out_keep(out_keep0), .out_tag(out_tag0), .out_auth_fail(out_af0), .busy(busy0),
        .done(done0), .timeout_err(terr0));
    aes_gcm_out_framer #(.TAG_BYTES(12), .TAG_TIMEOUT(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .enc_mode(enc_mode), .pld_zero(pld_zero),
        .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last), .in_data(in_data),
        .in_keep(in_keep), .tag_in(tag_in), .tag_valid(tag_valid), .auth_fail(auth_fail),
        .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1), .out_data(out_data1),
        .out_keep(out_keep1), .out_tag(out_tag1), .out_auth_fail(out_af1), .busy(busy1),
        .done(done1), .timeout_err(terr1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (out_valid0 && out_ready) q0.push_back('{out_data0, out_keep0, out_last0, out_tag0, out_af0, cyc});
        if (out_valid1 && out_ready) q1.push_back('{out_data1, out_keep1, out_last1, out_tag1, out_af1, cyc});
        if (done0) d0++;
        if (done1) d1++;
        if (stall0 && out_valid0) chk("stall_data_stable", out_data0, sdata0);
        if (out_valid0 && !out_ready) chk("in_ready_low_when_full", {127'd0, in_ready0}, 128'd0);
        stall0 = out_valid0 && !out_ready;
        sdata0 = out_data0;
    end

    always @(posedge clk) if (tog) begin
        #1;
        out_ready = ~out_ready;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        d0 = 0;
        d1 = 0;
    endtask

    task automatic do_start(input logic e, input logic z);
        start = 1'b1;
        enc_mode = e;
        pld_zero = z;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data = d;
        in_keep = k;
        in_last = l;
        @(negedge clk);
        while (!in_ready0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_accept", {127'd0, in_ready0}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic give_tag(input logic [127:0] t, input logic a);
        tag_valid = 1'b1;
        tag_in = t;
        auth_fail = a;
        tick(1);
        tag_valid = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target);
        int t = 0;
        while (((which == 0) ? d0 : d1) < target && t < 300) begin
            tick(1);
            t++;
        end
        chk("done_wait", 128'((which == 0) ? d0 : d1), 128'(target));
    endtask

    function automatic logic [127:0] pat(input int i);
        return {4{32'(32'hC0DE0000 + i)}};
    endfunction

    initial begin
        // Reset state
        tick(2);
        chk("rst_out_valid", {127'd0, out_valid0}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready0}, 128'd0);
        chk("rst_busy", {127'd0, busy0}, 128'd0);
        chk("rst_done", {127'd0, done0}, 128'd0);
        chk("rst_timeout_err", {127'd0, terr0}, 128'd0);
        chk("rst_out_data", out_data0, 128'd0);
        do_reset();
        chk("idle_in_ready", {127'd0, in_ready0}, 128'd0);

        // Encrypt, 3 beats, tag 2 cycles after last
        do_start(1'b1, 1'b0);
        chk("enc_busy", {127'd0, busy0}, 128'd1);
        for (int i = 0; i < 3; i++) send(pat(i), 16'hFFFF, i == 2);
        tick(1);
        give_tag(TAG, 1'b0);
        wait_done(0, 1);
        tick(3);
        chk("enc_done_once", 128'(d0), 128'd1);
        chk("enc_beats", 128'(q0.size()), 128'd4);
        if (q0.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk("enc_pld_data", q0[i].d, pat(i));
                chk("enc_pld_tag_last", {126'd0, q0[i].t, q0[i].l}, 128'd0);
            end
            chk("enc_tag_data", q0[3].d, TAG);
            chk("enc_tag_keep", {112'd0, q0[3].k}, 128'hFFFF);
            chk("enc_tag_flags", {126'd0, q0[3].t, q0[3].l}, 128'd3);
        end
        chk("enc_idle_after", {127'd0, busy0}, 128'd0);

        // Decrypt, 2 beats, last held until auth_fail=1 arrives 5 cycles later
        do_reset();
        do_start(1'b0, 1'b0);
        send(pat(10), 16'hFFFF, 1'b0);
        send(pat(11), 16'hFF00, 1'b1);
        tick(4);
        chk("dec_held_valid", {127'd0, out_valid0}, 128'd0);
        chk("dec_held_count", 128'(q0.size()), 128'd1);
        give_tag(128'd0, 1'b1);
        wait_done(0, 1);
        chk("dec_beats", 128'(q0.size()), 128'd2);
        if (q0.size() == 2) begin
            chk("dec_b0_last", {127'd0, q0[0].l}, 128'd0);
            chk("dec_b1_data", q0[1].d, pat(11));
            chk("dec_b1_keep", {112'd0, q0[1].k}, 128'hFF00);
            chk("dec_b1_last_af", {125'd0, q0[1].t, q0[1].l, q0[1].a}, 128'd3);
        end

        // Encrypt with TAG_BYTES=12, tag reported before in_last
        do_reset();
        do_start(1'b1, 1'b0);
        give_tag(TAG, 1'b0);
        send(pat(20), 16'hFFFF, 1'b0);
        send(pat(21), 16'hFFFF, 1'b1);
        wait_done(1, 1);
        chk("early_beats", 128'(q1.size()), 128'd3);
        if (q1.size() == 3) begin
            chk("early_tag_data", q1[2].d, TAG);
            chk("early_tag_keep", {112'd0, q1[2].k}, 128'hFFF0);
            chk("early_tag_flags", {126'd0, q1[2].t, q1[2].l}, 128'd3);
            chk("early_no_stall", 128'(q1[2].c - q1[1].c), 128'd1);
        end

        // Backpressure: out_ready toggling over a 4-beat encrypt
        do_reset();
        do_start(1'b1, 1'b0);
        tog = 1'b1;
        for (int i = 0; i < 4; i++) send(pat(30 + i), 16'hFFFF, i == 3);
        give_tag(TAG, 1'b0);
        wait_done(0, 1);
        tog = 1'b0;
        tick(1);
        out_ready = 1'b1;
        chk("bp_beats", 128'(q0.size()), 128'd5);
        if (q0.size() == 5) begin
            for (int i = 0; i < 4; i++) chk("bp_data", q0[i].d, pat(30 + i));
            chk("bp_tag", q0[4].d, TAG);
        end

        // Decrypt with empty payload, tag arrives
        do_reset();
        do_start(1'b0, 1'b1);
        tick(2);
        give_tag(128'd0, 1'b0);
        wait_done(0, 1);
        chk("pz_beats", 128'(q0.size()), 128'd1);
        if (q0.size() == 1) begin
            chk("pz_data", q0[0].d, 128'd0);
            chk("pz_keep", {112'd0, q0[0].k}, 128'd0);
            chk("pz_last_af", {126'd0, q0[0].l, q0[0].a}, 128'd2);
        end

        // Decrypt with empty payload, no tag: u1 times out after 8 cycles
        do_reset();
        do_start(1'b0, 1'b1);
        tick(7);
        chk("to_not_yet", {127'd0, terr1}, 128'd0);
        tick(1);
        chk("to_set", {127'd0, terr1}, 128'd1);
        chk("to_long_timer_clear", {127'd0, terr0}, 128'd0);
        wait_done(1, 1);
        chk("to_beats", 128'(q1.size()), 128'd1);
        if (q1.size() == 1) begin
            chk("to_keep", {112'd0, q1[0].k}, 128'd0);
            chk("to_last_af", {126'd0, q1[0].l, q1[0].a}, 128'd3);
        end
        tick(2);
        chk("to_sticky", {127'd0, terr1}, 128'd1);
        do_start(1'b1, 1'b0);
        chk("to_clear_on_start", {127'd0, terr1}, 128'd0);

        // Reset mid-payload, then a clean 1-beat frame
        do_reset();
        out_ready = 1'b0;
        do_start(1'b1, 1'b0);
        send(pat(40), 16'hFFFF, 1'b0);
        tick(1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {127'd0, out_valid0}, 128'd0);
        chk("mid_rst_busy", {127'd0, busy0}, 128'd0);
        chk("mid_rst_data", out_data0, 128'd0);
        chk("mid_rst_keep", {112'd0, out_keep0}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        q0.delete();
        q1.delete();
        d0 = 0;
        d1 = 0;
        do_start(1'b1, 1'b0);
        send(pat(41), 16'hFFFF, 1'b1);
        give_tag(TAG, 1'b0);
        wait_done(0, 1);
        chk("post_rst_beats", 128'(q0.size()), 128'd2);
        if (q0.size() == 2) begin
            chk("post_rst_data", q0[0].d, pat(41));
            chk("post_rst_tag", {127'd0, q0[1].t}, 128'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
